// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the shared sequential multiplier (mul_share_arb).
package mul_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_IDW  = $clog2(DEF_NREQ);

endpackage

// File: rtl/mul_seq_core.sv
// Shift-add multiplier engine: one bit of b per step, LSB first, into a 2W-bit accumulator.
// With MUL_EARLY_TERM_EN defined, done asserts on the step after which b has no set bits left.
module mul_seq_core
    import mul_share_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           step_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] z_o
);

    localparam int             CW       = $clog2(W + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);

    logic [2*W-1:0] a_q, a_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_s;

    // Step datapath: load on start, otherwise add shifted multiplicand when the current b bit is set.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            a_d   = {{W{1'b0}}, a_i};
            b_d   = b_i;
            acc_d = {(2*W){1'b0}};
            cnt_d = {CW{1'b0}};
        end else if (step_i) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end else begin
                acc_d = acc_q;
            end
            a_d   = {a_q[2*W-2:0], 1'b0};
            b_d   = {1'b0, b_q[W-1:1]};
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            acc_d = acc_q;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= {(2*W){1'b0}};
            b_q   <= {W{1'b0}};
            acc_q <= {(2*W){1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef MUL_EARLY_TERM_EN
    assign last_s = (cnt_q == CNT_LAST) || (b_q[W-1:1] == {(W-1){1'b0}});
`else
    assign last_s = (cnt_q == CNT_LAST);
`endif

    assign done_o = step_i && last_s;
    assign z_o    = acc_q;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter and IDLE/RUN/DONE controller sharing one mul_seq_core among NREQ requesters.
// Define MUL_EARLY_TERM_EN to finish a multiply as soon as the remaining bits of b are zero.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*W-1:0]          rsp_z,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    busy
);

    localparam int              IDW     = $clog2(NREQ);
    localparam logic [IDW-1:0]  ID_LAST = IDW'(NREQ - 1);
    localparam logic [IDW-1:0]  ID_ONE  = IDW'(32'd1);

    mul_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;

    logic           any_valid_s;
    logic [IDW-1:0] gnt_id_s;
    logic [NREQ-1:0] gnt_oh_s;
    logic [W-1:0]   a_sel_s;
    logic [W-1:0]   b_sel_s;
    logic           accept_s;
    logic           core_step_s;
    logic           core_done_s;
    logic [2*W-1:0] core_z_s;

    // Round-robin pick: first valid requester at or after ptr_q, wrapping to 0.
    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        any_valid_s = 1'b0;
        gnt_id_s    = {IDW{1'b0}};
        gnt_oh_s    = {NREQ{1'b0}};
        a_sel_s     = {W{1'b0}};
        b_sel_s     = {W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            idx = (idx >= NREQ) ? (idx - NREQ) : idx;
            sel = IDW'(idx);
            if (!any_valid_s && req_valid[sel]) begin
                any_valid_s   = 1'b1;
                gnt_id_s      = sel;
                gnt_oh_s[sel] = 1'b1;
                a_sel_s       = req_a[idx*W +: W];
                b_sel_s       = req_b[idx*W +: W];
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // Controller next state, accept strobe and pointer advance.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        accept_s    = 1'b0;
        core_step_s = 1'b0;
        req_ready   = {NREQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s && !rst) begin
                    req_ready = gnt_oh_s;
                    accept_s  = 1'b1;
                    id_d      = gnt_id_s;
`ifdef MUL_EARLY_TERM_EN
                    state_d   = (b_sel_s == {W{1'b0}}) ? ST_DONE : ST_RUN;
`else
                    state_d   = ST_RUN;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                core_step_s = 1'b1;
                if (core_done_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Handshake cycle never grants; the next grant is at the earliest one cycle later.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    ptr_d   = (id_q == ID_LAST) ? {IDW{1'b0}} : (id_q + ID_ONE);
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {IDW{1'b0}};
            id_q    <= {IDW{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

    mul_seq_core #(
        .W (W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept_s),
        .step_i  (core_step_s),
        .a_i     (a_sel_s),
        .b_i     (b_sel_s),
        .done_o  (core_done_s),
        .z_o     (core_z_s)
    );

    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_z     = core_z_s;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: stimulus pushes expected responses, a monitor pops and checks.
module tb_mul_share_arb;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_z;
    logic [1:0]        rsp_id;
    logic              busy;

    typedef struct {
        int          id;
        logic [15:0] z;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_valid = 1'b0;

    mul_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept-to-valid latency: early termination ends after the highest set bit of b.
    function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_EARLY_TERM_EN
        int hi = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) hi = i + 1;
        end
        return hi + 1;
`else
        return W + 1;
`endif
    endfunction

    // Monitor: latency on rsp_valid rise, data/id on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (|(req_valid & req_ready)) acc_cyc <= cyc;
            if (rsp_valid && !prev_valid) begin
                chk("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk($sformatf("latency_id%0d", exp_q[0].id), cyc - acc_cyc, exp_q[0].lat);
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("rsp_z_id%0d", e.id), rsp_z, e.z);
                chk("rsp_id", rsp_id, e.id);
            end
        end
        prev_valid <= rsp_valid;
    end

    task automatic push_exp(input int k, input logic [7:0] b, input logic [15:0] z);
        exp_t e;
        e.id = k; e.z = z; e.lat = exp_lat(b);
        exp_q.push_back(e);
    endtask

    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] z, input bit push);
        int n = 0;
        logic [NREQ-1:0] oh = '0;
        oh[k] = 1'b1;
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        req_valid[k]    = 1'b1;
        @(negedge clk);
        while (!req_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("grant_req%0d", k), req_ready, oh);
        if (push && req_ready[k]) push_exp(k, b, z);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           order [5] = '{0, 1, 2, 3, 0};
        logic [7:0]   av [4] = '{8'h12, 8'h0F, 8'h80, 8'hAB};
        logic [7:0]   bv [4] = '{8'h34, 8'h11, 8'h02, 8'h03};
        logic [15:0]  zv [4] = '{16'h03A8, 16'h00FF, 16'h0100, 16'h0201};
        logic [NREQ-1:0] oh;
        int n;

        rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_z", rsp_z, 0);
        chk("reset_rsp_id", rsp_id, 0);
        @(posedge clk);
        #1 req_valid = '0; rst = 1'b0;

        issue(0, 8'h0D, 8'h0B, 16'h008F, 1'b1);
        issue(2, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
        issue(1, 8'h00, 8'h00, 16'h0000, 1'b1);
        issue(3, 8'h55, 8'h01, 16'h0055, 1'b1);
        drain();

        // All requesters held valid: expect round-robin 0,1,2,3,0.
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*W +: W] = av[k];
            req_b[k*W +: W] = bv[k];
        end
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == '0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            oh = '0; oh[order[g]] = 1'b1;
            chk($sformatf("rr_grant%0d", g), req_ready, oh);
            push_exp(order[g], bv[order[g]], zv[order[g]]);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        drain();

        // Backpressure: response held while rsp_ready low, no grants meanwhile.
        rsp_ready = 1'b0;
        issue(1, 8'h07, 8'h06, 16'h002A, 1'b1);
        req_a[2*W +: W] = 8'h03; req_b[2*W +: W] = 8'h05; req_valid[2] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_z", rsp_z, 16'h002A);
            chk("hold_rsp_id", rsp_id, 1);
            chk("hold_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("no_grant_at_handshake", req_ready, 0);
        @(negedge clk);
        chk("grant_after_handshake", req_ready, 4'b0100);
        if (req_ready[2]) push_exp(2, 8'h05, 16'h000F);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        drain();

        // Reset during RUN discards the operation and resets the pointer.
        issue(3, 8'h11, 8'h22, 16'h0000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        req_a[0 +: W] = 8'h21; req_b[0 +: W] = 8'h09;
        req_valid = 4'b1001;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_during_rst", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", busy, 0);
        chk("rsp_valid_after_rst", rsp_valid, 0);
        chk("rsp_z_after_rst", rsp_z, 0);
        chk("grant_after_rst", req_ready, 4'b0001);
        if (req_ready[0]) push_exp(0, 8'h09, 16'h0129);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        issue(3, 8'h11, 8'h22, 16'h0242, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
